out_bram_reader: RTL and testbench

Drain engine for the output BRAM: on a start pulse it reads a contiguous run of 128-bit result words from the BRAM read port and presents them as a valid/ready stream toward the PS-side DMA or packer. It owns the BRAM read address and read enable, absorbs the BRAM's one-cycle read latency with a 2-entry output FIFO, and sustains one word per cycle when the sink is always ready.

---
 rtl/out_bram_reader.sv | 116 +++++++++++
 tb/tb_out_bram_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_bram_reader.sv
// Drains a contiguous run of words from the output BRAM into a valid/ready stream.
// A 2-entry FIFO absorbs the one-cycle BRAM read latency so a ready sink gets one word per cycle.
module out_bram_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_CNT   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH:0]   issue_left;
  logic                  pend;
  logic                  pend_last;
  logic [1:0]            occ;
  logic [1:0]            in_flight;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  handshake;
  logic                  accept;

  assign in_flight = occ + {1'b0, pend};
  assign handshake = m_valid & m_ready;
  assign accept    = (state == IDLE) & start;
  assign m_valid   = (occ != 2'd0);
  assign m_data    = fifo_data[rd_ptr];
  assign m_last    = m_valid & fifo_last[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (word_cnt == '0) ? FINISH : RUN;
      RUN:     if (handshake && m_last) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A read may be issued into a full pipeline only when the head leaves this same cycle.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    re   = 1'b0;
    case (state)
      RUN: begin
        busy = 1'b1;
        re   = (issue_left != '0) &&
               ((in_flight < 2'd2) || ((in_flight == 2'd2) && handshake));
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_left   <= '0;
      rd_addr      <= '0;
      pend         <= 1'b0;
      pend_last    <= 1'b0;
      occ          <= 2'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
    end else begin
      pend      <= re;
      pend_last <= re && (issue_left == ONE_CNT);
      if (accept && (word_cnt != '0)) begin
        rd_addr    <= base_addr;
        issue_left <= (word_cnt > DEPTH_CNT) ? DEPTH_CNT : word_cnt;
      end else if (re) begin
        rd_addr    <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
        issue_left <= issue_left - 1'b1;
      end
      // The last-word tag travels with the read so m_last needs no separate delivery counter.
      if (pend) begin
        fifo_data[wr_ptr] <= rd_data;
        fifo_last[wr_ptr] <= pend_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (handshake) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, pend} - {1'b0, handshake};
    end
  end

endmodule

// File: tb/tb_out_bram_reader.sv
// Bench for out_bram_reader: a queue-based model of the transfer, checked every cycle,
// driven by directed transfers with hand-computed cycle and data expectations.
module tb_out_bram_reader;

  localparam int AW    = 11;
  localparam int DW    = 128;
  localparam int DEPTH = 2048;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          start     = 1'b0;
  logic          m_ready   = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_cnt  = '0;
  logic [DW-1:0] rd_data   = '0;
  logic          busy, done, re, m_valid, m_last;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] m_data;

  int n_vec = 0;
  int n_err = 0;

  // Model state: words still owed to the sink and addresses still owed to the BRAM.
  logic [DW-1:0] exp_q [$];
  int            addr_q [$];
  int            outstanding = 0;
  bit            run = 0;
  bit            done_due = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  int            cyc = 0;
  int            t0 = 0;
  int            first_re, first_valid, done_cyc, popped, re_count, first_re_addr;
  logic [DW-1:0] first_data, last_data;

  out_bram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .re(re), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // BRAM holds its own address as data, with one cycle of read latency.
  always @(posedge clk) rd_data <= re ? DW'(rd_addr) : '0;

  task automatic checkBit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %b, expected %b (rel cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task automatic checkNum(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (rel cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task automatic checkWord(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (rel cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  task automatic checkOutput();
    bit hs;
    bit run_n;
    bit done_n;
    int n;
    if (rst) begin
      checkBit("reset busy", busy, 1'b0);
      checkBit("reset done", done, 1'b0);
      checkBit("reset re", re, 1'b0);
      checkNum("reset rd_addr", int'(rd_addr), 0);
      checkBit("reset m_valid", m_valid, 1'b0);
      checkWord("reset m_data", m_data, '0);
      checkBit("reset m_last", m_last, 1'b0);
      exp_q.delete();
      addr_q.delete();
      outstanding = 0;
      run = 0;
      done_due = 0;
      prev_stall = 0;
      return;
    end
    hs     = m_valid && m_ready;
    run_n  = run;
    done_n = 0;
    checkBit("done", done, done_due);
    checkBit("busy", busy, run);
    if (done) done_cyc = cyc - t0;
    if (prev_stall) begin
      checkBit("stall valid", m_valid, 1'b1);
      checkWord("stall data", m_data, prev_data);
      checkBit("stall last", m_last, prev_last);
    end
    if (m_valid) begin
      if (first_valid < 0) first_valid = cyc - t0;
      if (exp_q.size() == 0) checkBit("unexpected word", m_valid, 1'b0);
      else begin
        checkWord("m_data", m_data, exp_q[0]);
        checkBit("m_last", m_last, exp_q.size() == 1);
        if (hs) begin
          if (popped == 0) first_data = m_data;
          last_data = m_data;
          popped++;
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            run_n  = 0;
            done_n = 1;
          end
        end
      end
    end else begin
      checkBit("m_last without valid", m_last, 1'b0);
    end
    if (re) begin
      re_count++;
      if (first_re < 0) begin
        first_re      = cyc - t0;
        first_re_addr = int'(rd_addr);
      end
      if (addr_q.size() == 0) checkBit("unexpected re", re, 1'b0);
      else checkNum("rd_addr", int'(rd_addr), addr_q.pop_front());
      checkBit("re only with room", (outstanding < 2) || hs, 1'b1);
    end
    outstanding = outstanding + int'(re) - int'(hs);
    if (start && !run && !done_due) begin
      n = (int'(word_cnt) > DEPTH) ? DEPTH : int'(word_cnt);
      for (int k = 0; k < n; k++) begin
        addr_q.push_back((int'(base_addr) + k) % DEPTH);
        exp_q.push_back(DW'((int'(base_addr) + k) % DEPTH));
      end
      if (n == 0) done_n = 1;
      else        run_n  = 1;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    run        = run_n;
    done_due   = done_n;
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One transfer from cycle 0; optional second start (ss) and reset cycle (rst_cyc), -1 = none.
  task automatic applyStimulus(input int base, input int cnt, input bit toggle,
                               input int ss, input int ss_base, input int ss_cnt,
                               input int rst_cyc);
    int n;
    int budget;
    int rel;
    bit stop;
    n      = (cnt > DEPTH) ? DEPTH : cnt;
    budget = 4 * n + 20;
    t0 = cyc;
    first_re = -1; first_valid = -1; done_cyc = -1; popped = 0; re_count = 0;
    first_re_addr = -1; first_data = '0; last_data = '0;
    start     = 1'b1;
    base_addr = AW'(base);
    word_cnt  = (AW+1)'(cnt);
    stop      = 0;
    for (int i = 0; i < budget && !stop; i++) begin
      rel = cyc - t0;
      if (rel > 0) begin
        start = (rel == ss);
        if (rel == ss) begin
          base_addr = AW'(ss_base);
          word_cnt  = (AW+1)'(ss_cnt);
        end
      end
      m_ready = toggle ? ((rel % 3) == 0) : 1'b1;
      if (rel == rst_cyc) rst = 1'b1;
      step();
      if (rel == rst_cyc || done_cyc >= 0) stop = 1;
    end
    if (rst_cyc < 0) checkBit("done within budget", done_cyc >= 0, 1'b1);
    start   = 1'b0;
    m_ready = 1'b1;
    if (rst_cyc >= 0) begin
      step();
      rst = 1'b0;
    end
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    $display("[TB] basic transfer");
    applyStimulus(10, 4, 1'b0, -1, 0, 0, -1);
    checkNum("basic first re cycle", first_re, 1);
    checkNum("basic first re addr", first_re_addr, 10);
    checkNum("basic first valid cycle", first_valid, 3);
    checkWord("basic first word", first_data, 128'd10);
    checkWord("basic last word", last_data, 128'd13);
    checkNum("basic done cycle", done_cyc, 7);
    checkNum("basic words", popped, 4);
    checkNum("basic reads", re_count, 4);

    $display("[TB] backpressure");
    applyStimulus(0, 8, 1'b1, -1, 0, 0, -1);
    checkNum("bp words", popped, 8);
    checkWord("bp first word", first_data, 128'd0);
    checkWord("bp last word", last_data, 128'd7);
    checkNum("bp reads", re_count, 8);

    $display("[TB] address wrap");
    applyStimulus(2046, 4, 1'b0, -1, 0, 0, -1);
    checkNum("wrap first re addr", first_re_addr, 2046);
    checkWord("wrap first word", first_data, 128'd2046);
    checkWord("wrap last word", last_data, 128'd1);
    checkNum("wrap done cycle", done_cyc, 7);

    $display("[TB] zero count");
    applyStimulus(50, 0, 1'b0, -1, 0, 0, -1);
    checkNum("zero done cycle", done_cyc, 1);
    checkNum("zero reads", re_count, 0);
    checkNum("zero words", popped, 0);

    $display("[TB] clamp to depth");
    applyStimulus(5, 4000, 1'b0, -1, 0, 0, -1);
    checkNum("clamp words", popped, 2048);
    checkNum("clamp done cycle", done_cyc, 2051);
    checkWord("clamp last word", last_data, 128'd4);

    $display("[TB] start while busy");
    applyStimulus(100, 6, 1'b0, 2, 500, 3, -1);
    checkNum("busy-start words", popped, 6);
    checkWord("busy-start first word", first_data, 128'd100);
    checkWord("busy-start last word", last_data, 128'd105);
    checkNum("busy-start done cycle", done_cyc, 9);

    $display("[TB] start during done");
    applyStimulus(200, 6, 1'b0, 9, 600, 2, -1);
    checkNum("done-start words", popped, 6);
    checkWord("done-start last word", last_data, 128'd205);
    checkNum("done-start done cycle", done_cyc, 9);

    $display("[TB] reset mid-transfer");
    applyStimulus(300, 16, 1'b0, -1, 0, 0, 5);
    checkBit("no done after reset", done_cyc < 0, 1'b1);
    checkNum("words before reset", popped, 2);
    applyStimulus(700, 5, 1'b0, -1, 0, 0, -1);
    checkNum("post-reset first re addr", first_re_addr, 700);
    checkWord("post-reset first word", first_data, 128'd700);
    checkWord("post-reset last word", last_data, 128'd704);
    checkNum("post-reset done cycle", done_cyc, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
